snk_rom_loader: RTL and testbench
=================================

Name: snk_rom_loader

Overview:
- Sits between hps_io and SNK_TripleZ80, in the clk_53p6 domain.
- Consumes the ioctl byte stream from hps_io. Captures the game-select byte (index 1) and DIP bytes (index 254).
- For index 0 (ROM), decodes the address into one of four ROM regions and packs byte pairs into 16-bit words for the core's ROM write port.
- Applies back-pressure through ioctl_wait when the ROM port stalls, and reports load completion, byte count and checksum.

Parameters:
- R1_BASE, 25'h010000, first byte address of region 1 (must be even)
- R2_BASE, 25'h020000, first byte address of region 2 (must be even)
- R3_BASE, 25'h030000, first byte address of region 3 (must be even)
- ROM_END, 25'h100000, first address past ROM space; bytes at or above it are discarded

Ports:
- i_clk in 1: clk_53p6 system clock
- reset in 1: synchronous, active-high
- ioctl_download in 1: download active
- ioctl_index in 8: download index
- ioctl_wr in 1: byte strobe, 1 cycle
- ioctl_addr in 25: byte address
- ioctl_dout in 8: byte data
- ioctl_wait out 1: stall request to hps_io
- rom_region out 2: target region 0..3
- rom_addr out 24: region-relative byte address, bit0 = 0
- rom_data out 16: {odd byte, even byte}
- rom_we out 1: write request; held until accepted
- rom_ready in 1: write accepted in a cycle where rom_we=1
- game out 8: game select
- dsw1 out 8: DIP bank 0
- dsw2 out 8: DIP bank 1
- load_done out 1: ROM load complete
- rom_overflow out 1: at least one byte was at or above ROM_END
- byte_count out 25: ROM bytes accepted this load
- checksum out 16: mod-2^16 sum of ROM bytes accepted this load

Behaviour:
- Reset values: all outputs 0, except dsw1 = dsw2 = 8'hFF. FSM goes to IDLE, the skid buffer is emptied, and any pending word is dropped. A reset mid-download abandons that load; bytes arriving after reset are handled normally.
- Non-ROM indices:
  - Index 1, ioctl_wr, addr 0: game <= dout.
  - Index 254, ioctl_wr, addr < 8: addr 0 -> dsw1, addr 1 -> dsw2; addresses 2..7 are ignored.
  - These paths never assert ioctl_wait.
- Download start: a rising edge of ioctl_download with index 0 clears load_done, rom_overflow, byte_count and checksum, and moves IDLE -> LOAD.
- Region decode: addr < R1_BASE -> 0; addr < R2_BASE -> 1; addr < R3_BASE -> 2; otherwise 3. rom_addr = addr minus the region base.
- Bytes at or above ROM_END: set rom_overflow; the byte is not counted, not summed and not written.
- Packing (LOAD state):
  - Even-address byte: latch it as the low byte and set half_valid.
  - Odd-address byte: form the word {byte, low byte}, or {byte, 8'hFF} if half_valid=0. Go to WRITE.
  - Even byte while half_valid=1 (gap in the stream): first emit the pending word with high byte 8'hFF, then latch the new byte.
- Counters: byte_count += 1 and checksum += byte in the cycle each valid ROM byte is accepted.
- WRITE state:
  - rom_we=1 with stable region, address and data until the cycle rom_ready=1. Then rom_we=0 next cycle and return to LOAD.
  - ioctl_wait=1 in every cycle in WRITE.
  - Minimum latency from odd-byte ioctl_wr to rom_we is 1 cycle.
- Skid buffer: one entry. An ioctl_wr arriving while in WRITE (hps_io reacts to ioctl_wait one cycle late) is captured there and processed on return to LOAD, before any new byte. A second byte arriving while the buffer is full is a protocol violation; behaviour is unspecified and no assertion is required.
- Download end: a falling edge of ioctl_download while index 0 moves to FLUSH.
  - If half_valid=1, write the word with high byte 8'hFF through the same handshake; if the skid buffer is full, drain it first.
  - Then DONE: load_done=1. Stays in DONE until the next ROM download starts or reset.
- ioctl_wr with index 0 while in IDLE or DONE (no rising edge seen) is ignored.

Test Plan:
- Reset, then index 254 bytes 8'h3C at addr 0 and 8'hA5 at addr 1 -> dsw1=8'h3C, dsw2=8'hA5, ioctl_wait never 1. Index 1 byte 8'h02 at addr 0 -> game=8'h02.
- ROM bytes 8'h11 @0, 8'h22 @1 with rom_ready tied 1 -> one rom_we pulse: region 0, addr 0, data 16'h2211. After the download falls: load_done=1, byte_count=2, checksum=16'h0033.
- Bytes 8'hAA @25'h010000, 8'hBB @25'h010001 -> region 1, rom_addr 0, data 16'hBBAA. Bytes at 25'h030002 and 25'h030003 -> region 3, rom_addr 2.
- rom_ready held 0 for 5 cycles after rom_we; a byte arrives on the first wait cycle -> rom_we and data stable 5 cycles, ioctl_wait=1 throughout; the skidded byte is written or packed afterwards with no byte lost, and byte_count is exact.
- Odd-length load (3 bytes, last 8'h7E @2), then the download falls -> flush write of data 16'hFF7E at addr 2, then load_done=1. A byte at ROM_END -> rom_overflow=1 and byte_count unchanged.
- Assert reset while in WRITE -> next cycle rom_we=0, ioctl_wait=0, load_done=0. A new download then completes normally.

Source files
------------

// File: rtl/snk_rom_loader.sv
// snk_rom_loader: turns the hps_io ioctl byte stream into game/DIP settings and
//   16-bit ROM words for the core's ROM write port, with load stats.
// Latency: an odd ROM byte strobed at edge N raises rom_we after edge N (1 cycle).
// Backpressure: ioctl_wait is high in every cycle a word waits for rom_ready; one
//   byte sent during that window (hps_io reacts a cycle late) lands in a skid register.
//
// Ports:
//   i_clk, reset                 clk_53p6 clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout, ioctl_wait   hps_io download interface
//   rom_region/addr/data/we, rom_ready              ROM write port toward the core
//   game, dsw1, dsw2             settings captured from index 1 / index 254
//   load_done, rom_overflow, byte_count, checksum   status of the current ROM load
module snk_rom_loader #(
  parameter logic [24:0] R1_BASE = 25'h010000,
  parameter logic [24:0] R2_BASE = 25'h020000,
  parameter logic [24:0] R3_BASE = 25'h030000,
  parameter logic [24:0] ROM_END = 25'h100000
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [1:0]  rom_region,
  output logic [23:0] rom_addr,
  output logic [15:0] rom_data,
  output logic        rom_we,
  input  logic        rom_ready,
  output logic [7:0]  game,
  output logic [7:0]  dsw1,
  output logic [7:0]  dsw2,
  output logic        load_done,
  output logic        rom_overflow,
  output logic [24:0] byte_count,
  output logic [15:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      r_ret;        // state to resume once the pending word is accepted

  logic        r_dl_q;       // ioctl_download delayed, for edge detection
  logic        r_end_pend;   // download fell while a word was still in flight

  // One-entry skid register for a byte that arrives while stalled
  logic        r_skid_vld;
  logic [24:0] r_skid_addr;
  logic [7:0]  r_skid_dat;

  // Even byte waiting for its odd partner
  logic        r_half_vld;
  logic [7:0]  r_lo_dat;
  logic [24:0] r_lo_addr;

  logic        w_rise;
  logic        w_fall;
  logic        w_rom_wr;
  logic        w_src_vld;
  logic        w_src_skid;
  logic [24:0] w_src_addr;
  logic [7:0]  w_src_dat;
  logic        w_src_in_rom;
  logic [1:0]  w_src_region;
  logic [23:0] w_src_off;
  logic [1:0]  w_lo_region;
  logic [23:0] w_lo_off;

  function automatic logic [1:0] f_region(input logic [24:0] a);
    if (a < R1_BASE)      return 2'd0;
    else if (a < R2_BASE) return 2'd1;
    else if (a < R3_BASE) return 2'd2;
    else                  return 2'd3;
  endfunction

  // Region-relative word address; bit 0 is forced low.
  function automatic logic [23:0] f_offset(input logic [23:0] a, input logic [1:0] rg);
    logic [23:0] d;
    case (rg)
      2'd0:    d = a;
      2'd1:    d = a - R1_BASE[23:0];
      2'd2:    d = a - R2_BASE[23:0];
      default: d = a - R3_BASE[23:0];
    endcase
    return d & 24'hFFFFFE;
  endfunction

  assign w_rise   = ioctl_download & ~r_dl_q & (ioctl_index == 8'd0);
  assign w_fall   = ~ioctl_download & r_dl_q & (ioctl_index == 8'd0);
  assign w_rom_wr = ioctl_wr & (ioctl_index == 8'd0);

  // Byte to process this cycle: a skidded byte always goes before a new one.
  always_comb begin
    w_src_vld  = 1'b0;
    w_src_skid = 1'b0;
    w_src_addr = r_skid_addr;
    w_src_dat  = r_skid_dat;
    if ((r_state == S_LOAD) || (r_state == S_FLUSH)) begin
      if (r_skid_vld) begin
        w_src_vld  = 1'b1;
        w_src_skid = 1'b1;
      end else if ((r_state == S_LOAD) && w_rom_wr) begin
        w_src_vld  = 1'b1;
        w_src_addr = ioctl_addr;
        w_src_dat  = ioctl_dout;
      end
    end
  end

  assign w_src_in_rom = (w_src_addr < ROM_END);
  assign w_src_region = f_region(w_src_addr);
  assign w_src_off    = f_offset(w_src_addr[23:0], w_src_region);
  assign w_lo_region  = f_region(r_lo_addr);
  assign w_lo_off     = f_offset(r_lo_addr[23:0], w_lo_region);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ret        <= S_LOAD;
      r_dl_q       <= 1'b0;
      r_end_pend   <= 1'b0;
      r_skid_vld   <= 1'b0;
      r_skid_addr  <= '0;
      r_skid_dat   <= '0;
      r_half_vld   <= 1'b0;
      r_lo_dat     <= '0;
      r_lo_addr    <= '0;
      ioctl_wait   <= 1'b0;
      rom_region   <= '0;
      rom_addr     <= '0;
      rom_data     <= '0;
      rom_we       <= 1'b0;
      game         <= '0;
      dsw1         <= 8'hFF;
      dsw2         <= 8'hFF;
      load_done    <= 1'b0;
      rom_overflow <= 1'b0;
      byte_count   <= '0;
      checksum     <= '0;
    end else begin
      r_dl_q <= ioctl_download;

      // Settings bytes are taken in any state and never stall hps_io.
      if (ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0))
        game <= ioctl_dout;
      if (ioctl_wr && (ioctl_index == 8'd254)) begin
        if (ioctl_addr == 25'd0) dsw1 <= ioctl_dout;
        if (ioctl_addr == 25'd1) dsw2 <= ioctl_dout;
      end

      if (w_rise) begin
        // A new ROM download restarts from a clean slate whatever was going on.
        r_state      <= S_LOAD;
        r_end_pend   <= 1'b0;
        r_skid_vld   <= 1'b0;
        r_half_vld   <= 1'b0;
        rom_we       <= 1'b0;
        ioctl_wait   <= 1'b0;
        load_done    <= 1'b0;
        rom_overflow <= 1'b0;
        byte_count   <= '0;
        checksum     <= '0;
      end else begin
        if (w_fall && ((r_state == S_LOAD) || (r_state == S_WRITE) || (r_state == S_FLUSH)))
          r_end_pend <= 1'b1;

        case (r_state)
          S_LOAD, S_FLUSH: begin
            // Draining the skid frees it; a byte arriving the same cycle takes its place.
            if (w_src_skid) begin
              r_skid_vld  <= (r_state == S_LOAD) && w_rom_wr;
              r_skid_addr <= ioctl_addr;
              r_skid_dat  <= ioctl_dout;
            end

            if (w_src_vld) begin
              if (!w_src_in_rom) begin
                rom_overflow <= 1'b1;
              end else begin
                byte_count <= byte_count + 25'd1;
                checksum   <= checksum + {8'h00, w_src_dat};
                if (w_src_addr[0]) begin
                  // Odd byte completes a word; a missing low half reads as 8'hFF.
                  rom_data   <= {w_src_dat, (r_half_vld ? r_lo_dat : 8'hFF)};
                  rom_region <= w_src_region;
                  rom_addr   <= w_src_off;
                  r_half_vld <= 1'b0;
                  rom_we     <= 1'b1;
                  ioctl_wait <= 1'b1;
                  r_ret      <= r_state;
                  r_state    <= S_WRITE;
                end else begin
                  if (r_half_vld) begin
                    // Gap: the old low byte goes out alone while the new one is latched.
                    rom_data   <= {8'hFF, r_lo_dat};
                    rom_region <= w_lo_region;
                    rom_addr   <= w_lo_off;
                    rom_we     <= 1'b1;
                    ioctl_wait <= 1'b1;
                    r_ret      <= r_state;
                    r_state    <= S_WRITE;
                  end
                  r_lo_dat   <= w_src_dat;
                  r_lo_addr  <= w_src_addr;
                  r_half_vld <= 1'b1;
                end
              end
            end else if (r_state == S_LOAD) begin
              if (r_end_pend || w_fall)
                r_state <= S_FLUSH;
            end else begin
              // FLUSH with the skid empty: push out a trailing half word, then finish.
              if (r_half_vld) begin
                rom_data   <= {8'hFF, r_lo_dat};
                rom_region <= w_lo_region;
                rom_addr   <= w_lo_off;
                r_half_vld <= 1'b0;
                rom_we     <= 1'b1;
                ioctl_wait <= 1'b1;
                r_ret      <= S_FLUSH;
                r_state    <= S_WRITE;
              end else begin
                load_done <= 1'b1;
                r_state   <= S_DONE;
              end
            end
          end

          S_WRITE: begin
            if (w_rom_wr) begin
              r_skid_vld  <= 1'b1;
              r_skid_addr <= ioctl_addr;
              r_skid_dat  <= ioctl_dout;
            end
            if (rom_ready) begin
              rom_we     <= 1'b0;
              ioctl_wait <= 1'b0;
              r_state    <= r_ret;
            end
          end

          default: begin
            // IDLE and DONE ignore ROM bytes until a download rising edge.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snk_rom_loader.sv
module tb_snk_rom_loader;

  localparam logic [24:0] R1 = 25'h010000;
  localparam logic [24:0] R2 = 25'h020000;
  localparam logic [24:0] R3 = 25'h030000;
  localparam logic [24:0] RE = 25'h100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [1:0]  rom_region;
  logic [23:0] rom_addr;
  logic [15:0] rom_data;
  logic        rom_we;
  logic        rom_ready;
  logic [7:0]  game;
  logic [7:0]  dsw1;
  logic [7:0]  dsw2;
  logic        load_done;
  logic        rom_overflow;
  logic [24:0] byte_count;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  snk_rom_loader #(
    .R1_BASE(R1), .R2_BASE(R2), .R3_BASE(R3), .ROM_END(RE)
  ) dut (
    .i_clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .rom_region(rom_region), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_we(rom_we), .rom_ready(rom_ready),
    .game(game), .dsw1(dsw1), .dsw2(dsw2),
    .load_done(load_done), .rom_overflow(rom_overflow),
    .byte_count(byte_count), .checksum(checksum)
  );

  typedef struct packed {
    logic [1:0]  region;
    logic [23:0] addr;
    logic [15:0] data;
  } wr_t;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: expected words in order, plus expected load statistics.
  wr_t         exp_q[$];
  wr_t         wlog[$];
  int          run_log[$];
  bit          m_half;
  logic [7:0]  m_lo;
  logic [24:0] m_lo_addr;
  int          m_cnt;
  int          m_sum;
  bit          m_ovf;
  int          wait_cycles;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic wr_t mk(input logic [24:0] a, input logic [15:0] d);
    wr_t w;
    logic [24:0] base;
    logic [24:0] off;
    if (a < R1)      begin w.region = 2'd0; base = 25'd0; end
    else if (a < R2) begin w.region = 2'd1; base = R1; end
    else if (a < R3) begin w.region = 2'd2; base = R2; end
    else             begin w.region = 2'd3; base = R3; end
    off    = (a - base) & ~25'd1;
    w.addr = off[23:0];
    w.data = d;
    return w;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    wlog.delete();
    run_log.delete();
    m_half = 0; m_lo = 8'h00; m_lo_addr = '0;
    m_cnt = 0; m_sum = 0; m_ovf = 0;
  endtask

  task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
    if (a >= RE) begin
      m_ovf = 1;
    end else begin
      m_cnt++;
      m_sum = (m_sum + int'(d)) % 65536;
      if (a[0]) begin
        exp_q.push_back(mk(a, {d, (m_half ? m_lo : 8'hFF)}));
        m_half = 0;
      end else begin
        if (m_half) exp_q.push_back(mk(m_lo_addr, {8'hFF, m_lo}));
        m_lo = d; m_lo_addr = a; m_half = 1;
      end
    end
  endtask

  function automatic wr_t log_at(input int i);
    if (i < wlog.size()) return wlog[i];
    return '1;
  endfunction

  function automatic int run_at(input int i);
    if (i < run_log.size()) return run_log[i];
    return -1;
  endfunction

  // Per-cycle compare of the ROM write port against the model.
  bit  prev_we = 0;
  wr_t prev_w;
  int  run = 0;
  initial begin
    wr_t cur;
    wr_t e;
    forever begin
      @(negedge clk);
      cur = {rom_region, rom_addr, rom_data};
      if (reset) begin
        prev_we = 0;
        run = 0;
      end else begin
        if (ioctl_wait) wait_cycles++;
        if (prev_we) begin
          check("we_held", {63'd0, rom_we}, 64'd1);
          check("word_stable", {22'd0, cur}, {22'd0, prev_w});
        end
        if (rom_we) begin
          check("wait_in_write", {63'd0, ioctl_wait}, 64'd1);
          run++;
        end
        if (rom_we && rom_ready) begin
          wlog.push_back(cur);
          run_log.push_back(run);
          if (exp_q.size() == 0) begin
            check("unexpected_write", {22'd0, cur}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("write_word", {22'd0, cur}, {22'd0, e});
          end
          run = 0;
          prev_we = 0;
        end else begin
          prev_we = rom_we;
          prev_w  = cur;
          if (!rom_we) run = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                      input bit force_now);
    int n = 0;
    if (!force_now) begin
      while (ioctl_wait && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) check("wait_timeout", 64'(n), 64'd0);
    end
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    if (idx == 8'd0 && ioctl_download) model_byte(a, d);
  endtask

  task automatic start_rom();
    model_clear();
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_rom(input string tag);
    int n = 0;
    ioctl_download = 1'b0;
    if (m_half) exp_q.push_back(mk(m_lo_addr, {8'hFF, m_lo}));
    m_half = 0;
    while (!load_done && n < 100) begin
      tick();
      n++;
    end
    tick();
    check({tag, "_done"},  {63'd0, load_done}, 64'd1);
    check({tag, "_count"}, {39'd0, byte_count}, 64'(m_cnt));
    check({tag, "_sum"},   {48'd0, checksum}, 64'(m_sum));
    check({tag, "_ovf"},   {63'd0, rom_overflow}, {63'd0, m_ovf});
    check({tag, "_left"},  64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; rom_ready = 1'b1;
    model_clear();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_we",    {63'd0, rom_we}, 64'd0);
    check("rst_wait",  {63'd0, ioctl_wait}, 64'd0);
    check("rst_done",  {63'd0, load_done}, 64'd0);
    check("rst_ovf",   {63'd0, rom_overflow}, 64'd0);
    check("rst_count", {39'd0, byte_count}, 64'd0);
    check("rst_sum",   {48'd0, checksum}, 64'd0);
    check("rst_word",  {22'd0, rom_region, rom_addr, rom_data}, 64'd0);
    check("rst_game",  {56'd0, game}, 64'd0);
    check("rst_dsw1",  {56'd0, dsw1}, 64'hFF);
    check("rst_dsw2",  {56'd0, dsw2}, 64'hFF);

    // Settings downloads
    wait_cycles = 0;
    ioctl_index = 8'd254; tick();
    ioctl_download = 1'b1;
    send(8'd254, 25'd0, 8'h3C, 0);
    send(8'd254, 25'd1, 8'hA5, 0);
    send(8'd254, 25'd2, 8'h77, 0);
    ioctl_download = 1'b0; tick();
    ioctl_index = 8'd1; tick();
    ioctl_download = 1'b1;
    send(8'd1, 25'd0, 8'h02, 0);
    ioctl_download = 1'b0; tick();
    check("dsw1", {56'd0, dsw1}, 64'h3C);
    check("dsw2", {56'd0, dsw2}, 64'hA5);
    check("game", {56'd0, game}, 64'h02);
    check("cfg_no_wait", 64'(wait_cycles), 64'd0);
    check("cfg_no_done", {63'd0, load_done}, 64'd0);

    // A: one word, ready tied high
    rom_ready = 1'b1;
    start_rom();
    send(8'd0, 25'd0, 8'h11, 0);
    send(8'd0, 25'd1, 8'h22, 0);
    end_rom("A");
    check("A_nwr",   64'(wlog.size()), 64'd1);
    check("A_word",  {22'd0, log_at(0)}, {22'd0, 2'd0, 24'd0, 16'h2211});
    check("A_run",   64'(run_at(0)), 64'd1);
    check("A_count", {39'd0, byte_count}, 64'd2);
    check("A_sum",   {48'd0, checksum}, 64'h0033);

    // B: region decode
    start_rom();
    send(8'd0, 25'h010000, 8'hAA, 0);
    send(8'd0, 25'h010001, 8'hBB, 0);
    send(8'd0, 25'h030002, 8'h5A, 0);
    send(8'd0, 25'h030003, 8'hC3, 0);
    end_rom("B");
    check("B_w0",  {22'd0, log_at(0)}, {22'd0, 2'd1, 24'd0, 16'hBBAA});
    check("B_w1",  {22'd0, log_at(1)}, {22'd0, 2'd3, 24'd2, 16'hC35A});
    check("B_sum", {48'd0, checksum}, 64'h0282);

    // C: stalled port with a byte landing in the skid register
    rom_ready = 1'b0;
    start_rom();
    send(8'd0, 25'h100, 8'h01, 0);
    send(8'd0, 25'h101, 8'h02, 0);
    send(8'd0, 25'h102, 8'h03, 1);
    check("C_wait_hi", {63'd0, ioctl_wait}, 64'd1);
    repeat (3) tick();
    rom_ready = 1'b1;
    send(8'd0, 25'h103, 8'h04, 0);
    end_rom("C");
    check("C_w0",    {22'd0, log_at(0)}, {22'd0, 2'd0, 24'h000100, 16'h0201});
    check("C_run0",  64'(run_at(0)), 64'd5);
    check("C_w1",    {22'd0, log_at(1)}, {22'd0, 2'd0, 24'h000102, 16'h0403});
    check("C_count", {39'd0, byte_count}, 64'd4);
    check("C_sum",   {48'd0, checksum}, 64'h000A);

    // D: odd-length load and an out-of-range byte
    start_rom();
    send(8'd0, 25'd0, 8'h55, 0);
    send(8'd0, 25'd1, 8'h66, 0);
    send(8'd0, 25'd2, 8'h7E, 0);
    send(8'd0, RE, 8'h99, 0);
    check("D_ovf_mid",   {63'd0, rom_overflow}, 64'd1);
    check("D_count_mid", {39'd0, byte_count}, 64'd3);
    end_rom("D");
    check("D_flush", {22'd0, log_at(1)}, {22'd0, 2'd0, 24'd2, 16'hFF7E});
    check("D_sum",   {48'd0, checksum}, 64'h0139);

    // E: reset while a word is waiting for rom_ready
    rom_ready = 1'b0;
    start_rom();
    send(8'd0, 25'd0, 8'h01, 0);
    send(8'd0, 25'd1, 8'h02, 0);
    check("E_in_write", {63'd0, rom_we}, 64'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    check("E_rst_we",    {63'd0, rom_we}, 64'd0);
    check("E_rst_wait",  {63'd0, ioctl_wait}, 64'd0);
    check("E_rst_done",  {63'd0, load_done}, 64'd0);
    check("E_rst_count", {39'd0, byte_count}, 64'd0);
    check("E_rst_dsw1",  {56'd0, dsw1}, 64'hFF);
    tick();
    reset = 1'b0;
    rom_ready = 1'b1;
    model_clear();
    tick();

    // F: fresh load after reset, including a gap in the stream
    start_rom();
    send(8'd0, 25'h8, 8'h21, 0);
    send(8'd0, 25'hA, 8'h43, 0);
    send(8'd0, 25'hB, 8'h65, 0);
    end_rom("F");
    check("F_w0",  {22'd0, log_at(0)}, {22'd0, 2'd0, 24'h8, 16'hFF21});
    check("F_w1",  {22'd0, log_at(1)}, {22'd0, 2'd0, 24'hA, 16'h6543});
    check("F_sum", {48'd0, checksum}, 64'h00C9);

    // ROM strobes outside a download are ignored
    send(8'd0, 25'd0, 8'hEE, 0);
    repeat (2) tick();
    check("idle_ignore_count", {39'd0, byte_count}, 64'd3);
    check("idle_ignore_nwr",   64'(wlog.size()), 64'd2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
